time_set_controller: RTL and testbench

Sequencing controller for the alarm clock's digit counters. It generates the 1 Hz timekeeping tick in run mode. In set mode it walks through the time and alarm fields and issues single-cycle `Up` strobes to the counter of the selected field. Inputs are the Mode and Inc push-buttons (already debounced, asynchronous to `Clk`). Outputs drive the `Up`/`Enable` pins of the hour, minute and AM/PM counters for both time and alarm, plus display blink control.

---
 rtl/time_set_controller_pkg.sv | 54 +++++
 rtl/time_set_controller_button_sync_edge.sv | 34 +++
 rtl/time_set_controller.sv | 210 +++++++++++++++++++++
 tb/tb_time_set_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_controller_pkg.sv
// State codes, field bit positions and small decode helpers shared by the
// time-set controller and the display mux.
package time_set_controller_pkg;

    typedef logic [2:0] field_t;

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_T_HR  = 3'd1;
    localparam logic [2:0] ST_T_MIN = 3'd2;
    localparam logic [2:0] ST_T_AP  = 3'd3;
    localparam logic [2:0] ST_A_HR  = 3'd4;
    localparam logic [2:0] ST_A_MIN = 3'd5;
    localparam logic [2:0] ST_A_AP  = 3'd6;

    localparam logic [1:0] FLD_MIN = 2'd0;
    localparam logic [1:0] FLD_HR  = 2'd1;
    localparam logic [1:0] FLD_AP  = 2'd2;

    function automatic field_t next_field(input field_t st);
        field_t nxt;
        case (st)
            ST_RUN:   nxt = ST_T_HR;
            ST_T_HR:  nxt = ST_T_MIN;
            ST_T_MIN: nxt = ST_T_AP;
            ST_T_AP:  nxt = ST_A_HR;
            ST_A_HR:  nxt = ST_A_MIN;
            ST_A_MIN: nxt = ST_A_AP;
            ST_A_AP:  nxt = ST_RUN;
            default:  nxt = ST_RUN;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] field_strobe(input field_t st);
        logic [2:0] oh;
        oh = 3'b000;
        case (st)
            ST_T_HR,  ST_A_HR:  oh[FLD_HR]  = 1'b1;
            ST_T_MIN, ST_A_MIN: oh[FLD_MIN] = 1'b1;
            ST_T_AP,  ST_A_AP:  oh[FLD_AP]  = 1'b1;
            default:            oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic is_time_field(input field_t st);
        return (st == ST_T_HR) || (st == ST_T_MIN) || (st == ST_T_AP);
    endfunction

    function automatic logic is_alarm_field(input field_t st);
        return (st == ST_A_HR) || (st == ST_A_MIN) || (st == ST_A_AP);
    endfunction

endpackage

// File: rtl/time_set_controller_button_sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button with a registered
// rising-edge pulse and the synchronized level.
module button_sync_edge (
    input  logic Clk,
    input  logic Clr,
    input  logic btn,
    output logic rise,
    output logic level
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic rise_r;

    // Synchronizer chain plus one-cycle rising-edge register.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
        end
    end

    assign rise  = rise_r;
    assign level = sync2_r;

endmodule

// File: rtl/time_set_controller.sv
// Alarm-clock set-mode sequencer: 1 Hz tick in RUN, field walk on Mode,
// Up strobes with auto-repeat on Inc, inactivity timeout and field blink.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter logic [31:0] CLK_DIV     = 32'd50000000,
    parameter logic [31:0] HOLD_CYC    = 32'd25000000,
    parameter logic [31:0] REPEAT_CYC  = 32'd10000000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500000000,
    parameter logic [31:0] BLINK_CYC   = 32'd12500000
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       ModeBtn,
    input  logic       IncBtn,
    output logic       SecTick,
    output logic       SecClrN,
    output logic [2:0] TimeUp,
    output logic [2:0] AlmUp,
    output logic       Setting,
    output logic [2:0] Field,
    output logic       Blink
);

    logic        mode_rise_s;
    logic        mode_level_unused_s;
    logic        inc_rise_s;
    logic        inc_level_s;

    field_t      state_r;
    field_t      state_nxt_s;
    logic [31:0] presc_r;
    logic [31:0] presc_nxt_s;
    logic [31:0] tmo_r;
    logic [31:0] tmo_nxt_s;
    logic [31:0] rep_cnt_r;
    logic [31:0] rep_cnt_nxt_s;
    logic [31:0] rep_limit_s;
    logic [31:0] blink_cnt_r;
    logic [31:0] blink_cnt_nxt_s;
    logic        rep_act_r;
    logic        rep_act_nxt_s;
    logic        rep_hold_r;
    logic        rep_hold_nxt_s;
    logic        up_pulse_s;
    logic        in_set_s;
    logic        sec_tick_r;
    logic        sec_tick_nxt_s;
    logic        sec_clr_n_r;
    logic        setting_r;
    logic        blink_r;
    logic        blink_nxt_s;
    logic [2:0]  time_up_r;
    logic [2:0]  time_up_nxt_s;
    logic [2:0]  alm_up_r;
    logic [2:0]  alm_up_nxt_s;

    button_sync_edge u_mode_sync (
        .Clk   (Clk),
        .Clr   (Clr),
        .btn   (ModeBtn),
        .rise  (mode_rise_s),
        .level (mode_level_unused_s)
    );

    button_sync_edge u_inc_sync (
        .Clk   (Clk),
        .Clr   (Clr),
        .btn   (IncBtn),
        .rise  (inc_rise_s),
        .level (inc_level_s)
    );

    // State walk, timeout and Inc edge/auto-repeat; Mode beats Inc, Inc beats timeout.
    always_comb begin
        state_nxt_s    = state_r;
        tmo_nxt_s      = tmo_r;
        rep_act_nxt_s  = rep_act_r;
        rep_hold_nxt_s = rep_hold_r;
        rep_cnt_nxt_s  = rep_cnt_r;
        up_pulse_s     = 1'b0;
        in_set_s       = is_time_field(state_r) | is_alarm_field(state_r);
        rep_limit_s    = rep_hold_r ? (HOLD_CYC - 32'd1) : (REPEAT_CYC - 32'd1);
        if (state_r > ST_A_AP) begin
            state_nxt_s   = ST_RUN;
            tmo_nxt_s     = 32'd0;
            rep_act_nxt_s = 1'b0;
            rep_cnt_nxt_s = 32'd0;
        end else if (mode_rise_s) begin
            state_nxt_s   = next_field(state_r);
            tmo_nxt_s     = 32'd0;
            rep_act_nxt_s = 1'b0;
            rep_cnt_nxt_s = 32'd0;
        end else if (!in_set_s) begin
            tmo_nxt_s     = 32'd0;
            rep_act_nxt_s = 1'b0;
            rep_cnt_nxt_s = 32'd0;
        end else if (inc_rise_s) begin
            up_pulse_s     = 1'b1;
            tmo_nxt_s      = 32'd0;
            rep_act_nxt_s  = 1'b1;
            rep_hold_nxt_s = 1'b1;
            rep_cnt_nxt_s  = 32'd0;
        end else if (tmo_r == TIMEOUT_CYC - 32'd1) begin
            state_nxt_s   = ST_RUN;
            tmo_nxt_s     = 32'd0;
            rep_act_nxt_s = 1'b0;
            rep_cnt_nxt_s = 32'd0;
        end else begin
            tmo_nxt_s = tmo_r + 32'd1;
            if (rep_act_r && inc_level_s) begin
                if (rep_cnt_r == rep_limit_s) begin
                    up_pulse_s     = 1'b1;
                    rep_hold_nxt_s = 1'b0;
                    rep_cnt_nxt_s  = 32'd0;
                end else begin
                    rep_cnt_nxt_s = rep_cnt_r + 32'd1;
                end
            end else begin
                rep_act_nxt_s = 1'b0;
                rep_cnt_nxt_s = 32'd0;
            end
        end
    end

    // Prescaler, blink phase and Up strobe steering for the registered outputs.
    always_comb begin
        presc_nxt_s     = 32'd0;
        sec_tick_nxt_s  = 1'b0;
        blink_nxt_s     = 1'b1;
        blink_cnt_nxt_s = 32'd0;
        time_up_nxt_s   = 3'b000;
        alm_up_nxt_s    = 3'b000;
        // The prescaler only runs while RUN persists, so entry always restarts it at 0.
        if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
            if (presc_r == CLK_DIV - 32'd1) begin
                presc_nxt_s    = 32'd0;
                sec_tick_nxt_s = 1'b1;
            end else begin
                presc_nxt_s    = presc_r + 32'd1;
                sec_tick_nxt_s = 1'b0;
            end
        end else begin
            presc_nxt_s    = 32'd0;
            sec_tick_nxt_s = 1'b0;
        end
        if ((state_nxt_s == ST_RUN) || (state_nxt_s != state_r) || up_pulse_s) begin
            blink_nxt_s     = 1'b1;
            blink_cnt_nxt_s = 32'd0;
        end else if (blink_cnt_r == BLINK_CYC - 32'd1) begin
            blink_nxt_s     = ~blink_r;
            blink_cnt_nxt_s = 32'd0;
        end else begin
            blink_nxt_s     = blink_r;
            blink_cnt_nxt_s = blink_cnt_r + 32'd1;
        end
        if (up_pulse_s && is_time_field(state_r)) begin
            time_up_nxt_s = field_strobe(state_r);
        end else begin
            time_up_nxt_s = 3'b000;
        end
        if (up_pulse_s && is_alarm_field(state_r)) begin
            alm_up_nxt_s = field_strobe(state_r);
        end else begin
            alm_up_nxt_s = 3'b000;
        end
    end

    // State, counters and all output registers.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_r     <= ST_RUN;
            presc_r     <= 32'd0;
            tmo_r       <= 32'd0;
            rep_cnt_r   <= 32'd0;
            rep_act_r   <= 1'b0;
            rep_hold_r  <= 1'b0;
            blink_cnt_r <= 32'd0;
            blink_r     <= 1'b1;
            sec_tick_r  <= 1'b0;
            sec_clr_n_r <= 1'b1;
            setting_r   <= 1'b0;
            time_up_r   <= 3'b000;
            alm_up_r    <= 3'b000;
        end else begin
            state_r     <= state_nxt_s;
            presc_r     <= presc_nxt_s;
            tmo_r       <= tmo_nxt_s;
            rep_cnt_r   <= rep_cnt_nxt_s;
            rep_act_r   <= rep_act_nxt_s;
            rep_hold_r  <= rep_hold_nxt_s;
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_r     <= blink_nxt_s;
            sec_tick_r  <= sec_tick_nxt_s;
            sec_clr_n_r <= ~is_time_field(state_nxt_s);
            setting_r   <= (state_nxt_s != ST_RUN);
            time_up_r   <= time_up_nxt_s;
            alm_up_r    <= alm_up_nxt_s;
        end
    end

    assign SecTick = sec_tick_r;
    assign SecClrN = sec_clr_n_r;
    assign TimeUp  = time_up_r;
    assign AlmUp   = alm_up_r;
    assign Setting = setting_r;
    assign Field   = state_r;
    assign Blink   = blink_r;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed plus randomized bench for time_set_controller, checked every cycle
// against an event-timestamp reference model.
module tb_time_set_controller;

    localparam int CLK_DIV = 4;
    localparam int HOLD    = 8;
    localparam int REP     = 3;
    localparam int TMO     = 40;
    localparam int BLINK   = 2;
    localparam int HMAX    = 4096;

    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       ModeBtn = 1'b0;
    logic       IncBtn = 1'b0;
    logic       SecTick;
    logic       SecClrN;
    logic [2:0] TimeUp;
    logic [2:0] AlmUp;
    logic       Setting;
    logic [2:0] Field;
    logic       Blink;

    always #5 Clk = ~Clk;

    time_set_controller #(
        .CLK_DIV     (32'd4),
        .HOLD_CYC    (32'd8),
        .REPEAT_CYC  (32'd3),
        .TIMEOUT_CYC (32'd40),
        .BLINK_CYC   (32'd2)
    ) dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .ModeBtn (ModeBtn),
        .IncBtn  (IncBtn),
        .SecTick (SecTick),
        .SecClrN (SecClrN),
        .TimeUp  (TimeUp),
        .AlmUp   (AlmUp),
        .Setting (Setting),
        .Field   (Field),
        .Blink   (Blink)
    );

    int checks = 0;
    int failures = 0;
    int n = 0;
    bit hm [HMAX];
    bit hi [HMAX];

    // Model: field code plus timestamps of the last relevant events.
    int   m_field;
    int   m_entry;
    int   m_last_act;
    int   m_last_pulse;
    int   m_rep_start;
    bit   m_rep_ok;
    logic e_tick;
    logic [2:0] e_tup;
    logic [2:0] e_aup;
    int   tup_cnt;
    int   aup_cnt;
    int   tick_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    function automatic bit hist_m(input int idx);
        return (idx < 1) ? 1'b0 : hm[idx];
    endfunction

    function automatic bit hist_i(input int idx);
        return (idx < 1) ? 1'b0 : hi[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HMAX; i++) begin
            hm[i] = 1'b0;
            hi[i] = 1'b0;
        end
        n = 0;
        m_field = 0;
        m_entry = 0;
        m_last_act = 0;
        m_last_pulse = 0;
        m_rep_start = 0;
        m_rep_ok = 1'b0;
        e_tick = 1'b0;
        e_tup = 3'b000;
        e_aup = 3'b000;
    endtask

    // A button sampled high at edge j first counts at edge j+3.
    task automatic model_step();
        bit mev;
        bit iev;
        bit ilvl;
        bit pulse;
        int old;
        int d;
        logic [2:0] fb;
        mev = hist_m(n - 3) && !hist_m(n - 4);
        iev = hist_i(n - 3) && !hist_i(n - 4);
        ilvl = hist_i(n - 2);
        old = m_field;
        pulse = 1'b0;
        if (mev) begin
            m_field = (m_field + 1) % 7;
        end else if (m_field != 0) begin
            if (iev) begin
                pulse = 1'b1;
                m_last_act = n;
                m_rep_start = n;
                m_rep_ok = 1'b1;
            end else if (n - m_last_act == TMO) begin
                m_field = 0;
            end else if (m_rep_ok && ilvl) begin
                d = n - m_rep_start;
                pulse = (d == HOLD) || ((d > HOLD) && ((d - HOLD) % REP == 0));
            end else begin
                m_rep_ok = 1'b0;
            end
        end
        if (m_field != old) begin
            m_entry = n;
            m_last_act = n;
            m_rep_ok = 1'b0;
        end
        if (pulse) m_last_pulse = n;
        e_tick = (m_field == 0) && (old == 0) && (n > m_entry) && ((n - m_entry) % CLK_DIV == 0);
        case (old)
            1, 4:    fb = 3'b010;
            2, 5:    fb = 3'b001;
            3, 6:    fb = 3'b100;
            default: fb = 3'b000;
        endcase
        e_tup = (pulse && old >= 1 && old <= 3) ? fb : 3'b000;
        e_aup = (pulse && old >= 4) ? fb : 3'b000;
    endtask

    function automatic logic exp_blink();
        int r;
        if (m_field == 0) return 1'b1;
        r = (m_entry > m_last_pulse) ? m_entry : m_last_pulse;
        return (((n - r) / BLINK) % 2) == 0;
    endfunction

    task automatic check_all();
        chk("field",   32'(Field),   32'(m_field));
        chk("setting", 32'(Setting), 32'(m_field != 0));
        chk("secclrn", 32'(SecClrN), 32'(!(m_field >= 1 && m_field <= 3)));
        chk("sectick", 32'(SecTick), 32'(e_tick));
        chk("timeup",  32'(TimeUp),  32'(e_tup));
        chk("almup",   32'(AlmUp),   32'(e_aup));
        chk("blink",   32'(Blink),   32'(exp_blink()));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sectick"}, 32'(SecTick), 32'd0);
        chk({tag, "_secclrn"}, 32'(SecClrN), 32'd1);
        chk({tag, "_timeup"},  32'(TimeUp),  32'd0);
        chk({tag, "_almup"},   32'(AlmUp),   32'd0);
        chk({tag, "_setting"}, 32'(Setting), 32'd0);
        chk({tag, "_field"},   32'(Field),   32'd0);
        chk({tag, "_blink"},   32'(Blink),   32'd1);
    endtask

    task automatic cycle();
        @(posedge Clk);
        n++;
        if (n >= HMAX) begin
            failures++;
            $display("FAIL hist_overflow cyc=%0d limit=%0d", n, HMAX);
            $fatal(1, "history overflow");
        end
        hm[n] = ModeBtn;
        hi[n] = IncBtn;
        model_step();
        @(negedge Clk);
        check_all();
        if (TimeUp != 3'b000) tup_cnt++;
        if (AlmUp != 3'b000) aup_cnt++;
        if (SecTick) tick_cnt++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic press_mode();
        ModeBtn = 1'b1;
        run(2);
        ModeBtn = 1'b0;
        run(8);
    endtask

    initial begin
        model_reset();
        tup_cnt = 0;
        aup_cnt = 0;
        tick_cnt = 0;
        #12;
        chk_reset("rst");
        @(negedge Clk);
        Clr = 1'b1;

        // Idle RUN: ticks at 4, 8, 12, 16, 20.
        run(20);
        chk("idle_ticks", 32'(tick_cnt), 32'd5);

        // Full Mode walk back to RUN.
        for (int i = 1; i <= 7; i++) begin
            press_mode();
            chk("mode_walk", 32'(Field), 32'(i % 7));
        end
        run(6);

        // T_MIN, Inc held 18 sampled cycles: edge, hold, two repeats.
        press_mode();
        press_mode();
        chk("at_tmin", 32'(Field), 32'd2);
        tup_cnt = 0;
        aup_cnt = 0;
        IncBtn = 1'b1;
        run(18);
        IncBtn = 1'b0;
        run(10);
        chk("rep_pulses", 32'(tup_cnt), 32'd4);
        chk("rep_no_alm", 32'(aup_cnt), 32'd0);

        // A_AP, Mode and Inc together: Mode wins.
        for (int i = 0; i < 4; i++) press_mode();
        chk("at_aap", 32'(Field), 32'd6);
        aup_cnt = 0;
        ModeBtn = 1'b1;
        IncBtn = 1'b1;
        run(2);
        ModeBtn = 1'b0;
        IncBtn = 1'b0;
        run(8);
        chk("simul_field", 32'(Field), 32'd0);
        chk("simul_no_alm", 32'(aup_cnt), 32'd0);

        // T_HR idle until timeout.
        press_mode();
        chk("at_thr", 32'(Field), 32'd1);
        run(40);
        chk("timeout_field", 32'(Field), 32'd0);

        // A_HR repeat interrupted by Clr.
        for (int i = 0; i < 4; i++) press_mode();
        chk("at_ahr", 32'(Field), 32'd4);
        aup_cnt = 0;
        IncBtn = 1'b1;
        run(14);
        chk("pre_rst_pulses", 32'(aup_cnt), 32'd2);
        Clr = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        model_reset();
        Clr = 1'b1;
        aup_cnt = 0;
        run(40);
        chk("post_rst_no_alm", 32'(aup_cnt), 32'd0);
        IncBtn = 1'b0;
        run(5);

        // Randomized button activity.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) ModeBtn = ~ModeBtn;
            if ($urandom_range(0, 11) == 0) IncBtn = ~IncBtn;
            cycle();
        end
        ModeBtn = 1'b0;
        IncBtn = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
